// File: rtl/lm96570_spi_master_if.sv
// Control-plane command/readback bus for the LM96570 serial configuration master.
// The master modport belongs to the command issuer; the slave modport belongs to the SPI engine.
interface lm96570_spi_master_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              start;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rdata;

    modport master (output start, rw, addr, wdata, input busy, done, rdata);
    modport slave  (input start, rw, addr, wdata, output busy, done, rdata);
endinterface

// File: rtl/lm96570_spi_master.sv
// Serialises {rw, addr, wdata} onto SCLK/SDI, pulses SLE, and captures the SDO data field.
// All outputs are registered.
module lm96570_spi_master #(
    parameter int CLK_DIV = 4,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    lm96570_spi_master_if.slave   bus,
    output logic                  spi_sclk,
    output logic                  spi_sdi,
    input  logic                  spi_sdo,
    output logic                  spi_sle
);
    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int DIV_W   = $clog2(2 * CLK_DIV);
    localparam int BIT_W   = $clog2(FRAME_W);

    localparam logic [DIV_W-1:0] RISE_CNT = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] BIT_END  = DIV_W'(2 * CLK_DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]         state_q,   state_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0] shift_q,   shift_d;
    logic [DATA_W-1:0]  cap_q,     cap_d;
    logic [DATA_W-1:0]  rdata_q,   rdata_d;
    logic [1:0]         sync_q,    sync_d;
    logic               rw_q,      rw_d;
    logic               sclk_q,    sclk_d;
    logic               sdi_q,     sdi_d;
    logic               sle_q,     sle_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;

    // Next-state logic for the frame sequencer, SCLK divider and SDO capture.
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        cap_d     = cap_q;
        rdata_d   = rdata_q;
        sync_d    = {sync_q[0], spi_sdo};
        rw_d      = rw_q;
        sclk_d    = sclk_q;
        sdi_d     = sdi_q;
        sle_d     = sle_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    // MSB goes straight to SDI; the shift register holds the remaining bits.
                    sdi_d     = bus.rw;
                    shift_d   = {bus.addr, bus.wdata, 1'b0};
                    rw_d      = bus.rw;
                    bit_cnt_d = BIT_W'(FRAME_W - 1);
                    div_cnt_d = '0;
                    busy_d    = 1'b1;
                    state_d   = S_SHIFT;
                end else begin
                    busy_d    = 1'b0;
                end
            end
            S_SHIFT: begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
                if (div_cnt_q == RISE_CNT) begin
                    sclk_d = 1'b1;
                end else if (div_cnt_q == BIT_END) begin
                    // Last cycle of the high phase: sample SDO, then start the next bit.
                    sclk_d    = 1'b0;
                    div_cnt_d = '0;
                    if (bit_cnt_q < BIT_W'(DATA_W)) begin
                        cap_d = {cap_q[DATA_W-2:0], sync_q[1]};
                    end else begin
                        cap_d = cap_q;
                    end
                    if (bit_cnt_q == '0) begin
                        sdi_d   = 1'b0;
                        sle_d   = 1'b1;
                        state_d = S_LATCH;
                    end else begin
                        bit_cnt_d = bit_cnt_q - BIT_W'(1);
                        sdi_d     = shift_q[FRAME_W-1];
                        shift_d   = {shift_q[FRAME_W-2:0], 1'b0};
                    end
                end else begin
                    sclk_d = sclk_q;
                end
            end
            S_LATCH: begin
                if (div_cnt_q == BIT_END) begin
                    div_cnt_d = '0;
                    sle_d     = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = S_DONE;
                    if (rw_q) begin
                        rdata_d = cap_q;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                sclk_d  = 1'b0;
                sle_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            cap_q     <= '0;
            rdata_q   <= '0;
            sync_q    <= 2'b00;
            rw_q      <= 1'b0;
            sclk_q    <= 1'b0;
            sdi_q     <= 1'b0;
            sle_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            cap_q     <= cap_d;
            rdata_q   <= rdata_d;
            sync_q    <= sync_d;
            rw_q      <= rw_d;
            sclk_q    <= sclk_d;
            sdi_q     <= sdi_d;
            sle_q     <= sle_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign spi_sclk  = sclk_q;
    assign spi_sdi   = sdi_q;
    assign spi_sle   = sle_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.rdata = rdata_q;
endmodule

// File: doc/lm96570_spi_master.md
# lm96570_spi_master

Serial-interface controller for the LM96570 beamformer configuration port. Takes a register-access command (read/write, address, write data) from the control plane, serialises it onto the chip's SCLK/SDI/SLE pins, and captures the SDO readback. The 32-bit readback word on `rdata` is the value presented to the downstream LM96570 readback PIO (`in_port` of the spi_out input port).

## Interface
Parameters:
- `CLK_DIV`, 4: clk cycles per SCLK half-period; legal range 3 to 255.
- `ADDR_W`, 5: register address width.
- `DATA_W`, 32: data field width.

Ports:
- `clk`  in  1  system clock, single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  command request; sampled only when `busy`=0.
- `rw`  in  1  1 = read, 0 = write; captured with `start`.
- `addr`  in  ADDR_W  register address; captured with `start`.
- `wdata`  in  DATA_W  write data; captured with `start`; don't-care for reads.
- `busy`  out  1  high from the cycle after an accepted `start` until the cycle `done` is high.
- `done`  out  1  one-cycle completion pulse.
- `rdata`  out  DATA_W  last read result; drives the readback PIO.
- `spi_sclk`  out  1  serial clock to LM96570, idle low.
- `spi_sdi`  out  1  serial data to LM96570, MSB first.
- `spi_sdo`  in  1  serial readback from LM96570, asynchronous to `clk`.
- `spi_sle`  out  1  latch enable, high only during the latch phase.

## Operation
- Frame: `FRAME_W` = 1+ADDR_W+DATA_W bits (38 by default), shifted MSB first as {rw, addr, wdata}.
- FSM states:
  - IDLE: `busy`=0. `start`=1 captures the frame into the shift register and the bit counter (FRAME_W-1), then moves to SHIFT.
  - SHIFT: one bit per SCLK period.
  - LATCH: `spi_sle`=1 for one SCLK period (2·CLK_DIV cycles) with `spi_sclk` low.
  - DONE: single cycle. `done`=1, `busy`=0; returns to IDLE.
- Bit period: SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles. `spi_sdi` updates on the first cycle of the low phase and is stable through the rising edge.
- SDO path: `spi_sdo` passes through a 2-flop synchroniser. The synchronised value is sampled on the last cycle of each high phase and shifted into a DATA_W capture register. Only the final DATA_W bit periods (the data field) are captured.
- `rdata` updates in the DONE cycle, and only when the captured `rw`=1. Writes leave `rdata` unchanged.
- `start` while `busy`=1 is ignored: no queuing, no effect on the current frame.
- `start` in the DONE cycle is also ignored. A new command is accepted from the first IDLE cycle after DONE.
- Reset (any state, including mid-frame) at the next clk edge:
  - State goes to IDLE.
  - `busy`, `done`, `spi_sclk`, `spi_sdi` = 0; `spi_sle` = 0.
  - `rdata` = 0; capture register and synchroniser cleared.
  - No `done` is issued for the aborted frame.

## Timing
- All outputs are registered; no combinational path from input to output.
- Reset values: `busy`=0, `done`=0, `rdata`=0, `spi_sclk`=0, `spi_sdi`=0, `spi_sle`=0.
- With `start` sampled at edge T0:
  - `busy`=1 and the first SCLK low phase begin at T0+1.
  - First SCLK rising edge at T0+1+CLK_DIV.
  - LATCH begins at T0+1+FRAME_W·2·CLK_DIV.
  - `done` is high in cycle T0+1+(FRAME_W+1)·2·CLK_DIV: cycle 313 for default parameters.
- The device must drive `spi_sdo` at least 3 clk cycles before the sampling point. This holds when CLK_DIV ≥ 3 and SDO changes on the falling edge.

## Test plan
- Write {rw=0, addr=0x0A, wdata=0xDEADBEEF}, CLK_DIV=4:
  - SDI shows the 38-bit pattern 0_01010_DEADBEEF, MSB first.
  - 38 SCLK pulses, each 8 cycles.
  - SLE high for 8 cycles.
  - `done` at cycle 313.
  - `rdata` unchanged.
- Read {rw=1, addr=0x03}: SDO model returns 0x12345678 on the data field, changing on SCLK falling edges. `rdata`=0x12345678 in the `done` cycle; the readback PIO registers it the next cycle.
- `start` pulsed at cycles 50 and 200 during an active frame: ignored; a single `done` at 313.
- `reset` asserted at cycle 100 of a read:
  - Next edge: all outputs at reset values, `rdata`=0.
  - No `done` pulse.
  - A subsequent write completes normally.
- Back-to-back: first `start` accepted; `start` held high through the `done` cycle is ignored. The second command starts in the first IDLE cycle after `done` and completes 313 cycles later.
- CLK_DIV=3: read returning 0xA5A5A5A5 captures correctly; `done` at cycle 1+39·6=235.
